// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, unsigned or
// two's-complement operands chosen per operation, valid/ready on both sides.
module seq_mult #(
   parameter int N         = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   input  logic           is_signed,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] p,
   output logic           busy
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q;
   logic [N:0]     acc_q;
   logic [N-1:0]   mcand_q;
   logic [N-1:0]   mplier_q;
   logic           neg_q;
   logic [CW-1:0]  cnt_q;
   logic           in_ready_q;
   logic           out_valid_q;
   logic           busy_q;
   logic [2*N-1:0] p_q;

   logic           sm;
   logic [N-1:0]   a_mag;
   logic [N-1:0]   b_mag;
   logic [N:0]     sum;
   logic [N:0]     acc_d;
   logic [N-1:0]   mplier_d;
   logic [2*N-1:0] prod_d;

   // The datapath works on magnitudes; the sign is re-applied once at the end.
   always_comb begin
      sm       = is_signed & SIGNED_EN;
      a_mag    = (sm && a[N-1]) ? -a : a;
      b_mag    = (sm && b[N-1]) ? -b : b;
      sum      = mplier_q[0] ? (acc_q + {1'b0, mcand_q}) : acc_q;
      acc_d    = {1'b0, sum[N:1]};
      mplier_d = {sum[0], mplier_q[N-1:1]};
      prod_d   = {acc_d[N-1:0], mplier_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         neg_q       <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         p_q         <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               in_ready_q <= 1'b1;
               if (in_valid && in_ready_q) begin
                  state_q    <= S_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  mcand_q    <= a_mag;
                  mplier_q   <= b_mag;
                  acc_q      <= '0;
                  cnt_q      <= '0;
                  neg_q      <= sm & (a[N-1] ^ b[N-1]);
               end
            end
            S_RUN: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_d;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  p_q         <= neg_q ? -prod_d : prod_d;
               end
            end
            S_DONE: begin
               // in_ready rises only after this edge, so nothing is accepted while DONE
               if (out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign p         = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: a signed-capable instance and an unsigned-only
// instance share stimulus; a monitor pops expected products on each output handshake.
module tb_seq_mult;

   localparam int N = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          out_ready;
   logic          is_signed;
   logic [N-1:0]  a;
   logic [N-1:0]  b;
   logic          in_ready,  out_valid,  busy;
   logic          in_ready_u, out_valid_u, busy_u;
   logic [2*N-1:0] p, p_u;

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;
   int last_acc = 0;
   bit last_acc_ok = 0;
   bit b2b_on = 0;
   bit hold_valid = 0;
   int tx_n = 0;
   logic [2*N-1:0] q_s[$];
   logic [2*N-1:0] q_u[$];

   seq_mult #(.N(N), .SIGNED_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
      .out_ready(out_ready), .p(p), .busy(busy)
   );

   seq_mult #(.N(N), .SIGNED_EN(1'b0)) u_dut_u (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
      .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid_u),
      .out_ready(out_ready), .p(p_u), .busy(busy_u)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [2*N-1:0] mdl(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
      logic signed [2*N-1:0] xs, ys;
      if (s) begin
         xs = {{N{x[N-1]}}, x};
         ys = {{N{y[N-1]}}, y};
      end else begin
         xs = {{N{1'b0}}, x};
         ys = {{N{1'b0}}, y};
      end
      return (2*N)'(xs * ys);
   endfunction

   task automatic issue(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic si,
                        input logic [2*N-1:0] es, input logic [2*N-1:0] eu);
      bit done = 0;
      a = ai; b = bi; is_signed = si; in_valid = 1'b1;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            q_s.push_back(es);
            q_u.push_back(eu);
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!done) begin
         n_chk++;
         $display("FAIL accept_timeout: in_ready never high for a=%h b=%h", ai, bi);
      end
      if (!hold_valid) in_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (q_s.size() == 0 && q_u.size() == 0) done = 1;
      end
      if (!done) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d products still pending", q_s.size());
      end
      @(posedge clk); #1;
   endtask

   // Monitor: accept spacing, output latency and product scoreboard
   initial begin
      bit ov_prev = 0;
      logic [2*N-1:0] es, eu;
      forever begin
         @(negedge clk);
         if (rst) begin
            ov_prev = 0;
            continue;
         end
         if (in_valid && in_ready) begin
            if (b2b_on && last_acc_ok) check("accept_spacing", 32'(cyc + 1 - last_acc), N + 2);
            last_acc = cyc + 1;
            last_acc_ok = 1;
         end
         if (out_valid && !ov_prev) check("latency", 32'(cyc - last_acc), N);
         ov_prev = out_valid;
         if (out_valid && out_ready) begin
            if (q_s.size() == 0 || q_u.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_output: p=%h with nothing expected", p);
            end else begin
               es = q_s.pop_front();
               eu = q_u.pop_front();
               tx_n++;
               $display("tx %0d: p=%h (exp %h) unsigned-only p=%h (exp %h)", tx_n, p, es, p_u, eu);
               check("product", p, es);
               check("product_unsigned_inst", p_u, eu);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] x, y;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; is_signed = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_p", p, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("in_ready_after_release", in_ready, 1);

      // directed products
      issue(8'hFF, 8'hFF, 1'b0, 16'hFE01, 16'hFE01);
      drain();
      issue(8'h80, 8'h80, 1'b1, 16'h4000, 16'h4000);
      issue(8'hFF, 8'h7F, 1'b1, 16'hFF81, 16'h7E81);
      issue(8'h00, 8'h85, 1'b1, 16'h0000, 16'h0000);
      issue(8'h85, 8'h00, 1'b1, 16'h0000, 16'h0000);
      issue(8'h80, 8'h02, 1'b0, 16'h0100, 16'h0100);
      issue(8'hFF, 8'h02, 1'b1, 16'hFFFE, 16'h01FE);
      drain();

      // backpressure
      out_ready = 1'b0;
      issue(8'h7F, 8'h80, 1'b1, 16'hC080, 16'h3F80);
      for (int i = 0; i < 40 && !out_valid; i++) @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         a = 8'h11; b = 8'h22; in_valid = (i % 2) == 0;
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_p_stable", p, 16'hC080);
         check("bp_in_ready", in_ready, 0);
         check("bp_busy", busy, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_out_valid", out_valid, 0);
      check("release_in_ready", in_ready, 1);
      check("release_busy", busy, 0);
      check("release_p_kept", p, 16'hC080);

      // reset in the middle of RUN
      issue(8'h12, 8'h34, 1'b0, 16'h03A8, 16'h03A8);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      void'(q_s.pop_back());
      void'(q_u.pop_back());
      check("midrun_rst_out_valid", out_valid, 0);
      check("midrun_rst_p", p, 0);
      check("midrun_rst_in_ready", in_ready, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrun_in_ready_release", in_ready, 1);
      repeat (N + 2) @(posedge clk);
      #1;
      check("midrun_no_output", out_valid, 0);
      issue(8'h03, 8'h05, 1'b0, 16'h000F, 16'h000F);
      drain();

      // back-to-back random operations, signed then unsigned
      b2b_on = 1; last_acc_ok = 0; hold_valid = 1; out_ready = 1'b1;
      for (int m = 1; m >= 0; m--) begin
         for (int i = 0; i < 20; i++) begin
            x = N'($urandom_range(0, 255));
            y = N'($urandom_range(0, 255));
            issue(x, y, 1'(m), mdl(x, y, 1'(m)), mdl(x, y, 1'b0));
         end
      end
      hold_valid = 0; in_valid = 1'b0;
      drain();
      b2b_on = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
